ps2_rx_frame: RTL and testbench
===============================

# ps2_rx_frame

Receive-side PS/2 frame decoder that sits directly upstream of the keyboard make/break tracker. It synchronises and de-glitches the raw keyboard clock/data lines and assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop). It presents each valid byte with a one-cycle strobe, in the `received_data` / `received_data_en` form the tracker consumes. Receive only: the block never drives the PS/2 lines.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronised samples needed before the filtered PS/2 clock changes; range 2..31.
- `TIMEOUT_CYCLES`, default 5000: cycles without a filtered falling edge, mid-frame, before the frame is aborted (100 µs at 50 MHz); range ≥ 16.
- `clock`  in  1  system clock (50 MHz); all state on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_dat`  in  1  raw PS/2 data pin, asynchronous.
- `received_data`  out  8  last accepted byte; holds until the next accepted byte.
- `received_data_en`  out  1  one-cycle strobe; `received_data` is new in that cycle.
- `parity_error`  out  1  one-cycle pulse when a frame is dropped for bad parity.
- `frame_error`  out  1  one-cycle pulse for a bad start bit, bad stop bit, or timeout abort.

## Operation
- Both pins pass through a 2-flop synchroniser.
- `sclk` (filtered clock) resets to 1. It takes a new value only after FILTER_LEN consecutive synchronised clock samples equal that value.
- A falling edge (`fall`) is a 1→0 change of `sclk`. The data bit is the synchronised `ps2_dat` sampled in the `fall` cycle.
- **IDLE**, on `fall`:
  - bit = 0 → DATA, bit count = 0.
  - bit = 1 → stay IDLE, pulse `frame_error`.
- **DATA**, on `fall`: shift the bit in LSB-first (bit0 arrives first). After the 8th bit → PARITY.
- **PARITY**, on `fall`: store the bit → STOP.
- **STOP**, on `fall`:
  - stop bit = 0 → `frame_error`, no strobe.
  - parity bad (XOR of data and parity bit ≠ 1) → `parity_error`, no strobe.
  - otherwise load `received_data` and strobe `received_data_en`.
  - In every case → IDLE.
- **Timeout:** the counter clears on every `fall` and whenever the block is in IDLE. When not in IDLE and the counter reaches TIMEOUT_CYCLES−1:
  - next state IDLE, shift register and bit count cleared;
  - `frame_error` pulses.
- **Simultaneous `fall` and timeout:** `fall` wins; the counter clears and the bit is taken.
- Consecutive frames need no idle gap beyond one PS/2 clock high phase. Back-to-back bytes (E0, F0, code) each get their own strobe.

## Timing
- Reset values: `received_data` = 8'h00; `received_data_en`, `parity_error`, `frame_error` = 0; state IDLE; `sclk` = 1; counters 0.
- Reset asserted mid-frame aborts immediately with no strobe. The first frame after release decodes normally.
- Pin-to-`fall` latency is 2 + FILTER_LEN cycles from the pin falling edge.
- `received_data_en`, `parity_error` and `frame_error` all rise in the cycle after the `fall` that triggers them (registered outputs). Each is high for exactly 1 cycle.
- At most one of the three outputs is high in any cycle.
- Glitches on `ps2_clk` shorter than FILTER_LEN cycles produce no `fall`.
- Counter widths: `$clog2(TIMEOUT_CYCLES)` and `$clog2(FILTER_LEN+1)`. Counters saturate and never wrap.

## Configuration
- `PS2_RX_PARITY_CHECK_EN` defined: parity is checked as above.
- `PS2_RX_PARITY_CHECK_EN` undefined:
  - the parity bit is consumed but ignored;
  - a frame with a good stop bit always strobes;
  - `parity_error` is tied to 0.
- Start/stop/timeout checks are unaffected in both builds.

## Structure
- `ps2_pkg` holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - `PS2_DATA_BITS` = 8;
  - the common keyboard code constants E0 and F0.
- One sub-module, `ps2_line_filter`: 2-flop synchroniser plus FILTER_LEN debounce, outputting `sclk`, `sdat` and the `fall` pulse. Instantiated once, covering both lines.

## Test plan
- **Valid byte:** frame with byte 0x1D and parity 1 → exactly one `received_data_en`, `received_data` = 8'h1D, no error pulses.
- **Back-to-back frames:** 0xF0 (parity 1) then 0x29 (parity 0) → two strobes carrying F0 then 29; `received_data` holds 29 afterwards.
- **Bad parity:** 0xE0 sent with parity 1:
  - macro defined → `parity_error` pulse, no strobe, `received_data` unchanged;
  - macro undefined → strobe with E0.
- **Frame errors:**
  - start bit 1 → `frame_error`, state stays IDLE;
  - stop bit 0 on 0x1C → `frame_error`, no strobe.
- **Timeout:** clock stops after 4 data bits for ≥ 5000 cycles → `frame_error` at cycle 5000 after the last `fall`. A following full 0x75 frame → strobe with 75.
- **Glitch and reset:**
  - 3-cycle low glitch on `ps2_clk` (FILTER_LEN = 8) → no bit taken;
  - `resetn` low mid-frame → all outputs 0 immediately. The next 0x5A frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame FSM states, frame
// payload width and common keyboard prefix codes.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int unsigned PS2_DATA_BITS = 8;

    localparam logic [7:0] PS2_CODE_E0 = 8'hE0;
    localparam logic [7:0] PS2_CODE_F0 = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser for both PS/2 lines plus a FILTER_LEN-sample
// debounce on the clock line. Emits the filtered clock level, the
// synchronised data level and a one-cycle pulse on each filtered falling edge.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clock,
    input  logic resetn,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic sclk,
    output logic sdat,
    output logic fall
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic [CW-1:0] cnt;

    assign sdat = dat_sync[1];

    // Bring both asynchronous pins into the clock domain; lines idle high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    // Accept a new clock level only after FILTER_LEN consecutive agreeing samples.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sclk <= 1'b1;
            cnt  <= '0;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == sclk) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                sclk <= clk_sync[1];
                cnt  <= '0;
                fall <= sclk;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 receive frame decoder: start, 8 data bits LSB-first, odd parity, stop.
// Presents each good byte on received_data with a one-cycle received_data_en.
// Optional feature macro: PS2_RX_PARITY_CHECK_EN enables parity checking;
// without it the parity bit is consumed but ignored and parity_error is 0.
import ps2_pkg::*;

module ps2_rx_frame #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     ps2_clk,
    input  logic                     ps2_dat,
    output logic [PS2_DATA_BITS-1:0] received_data,
    output logic                     received_data_en,
    output logic                     parity_error,
    output logic                     frame_error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned BW = $clog2(PS2_DATA_BITS);

    logic sclk;
    logic sdat;
    logic fall;
    logic take;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clock   (clock),
        .resetn  (resetn),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .sclk    (sclk),
        .sdat    (sdat),
        .fall    (fall)
    );

    // fall is registered alongside sclk, so it always coincides with sclk low
    assign take = fall & ~sclk;

    ps2_state_t               state;
    logic [PS2_DATA_BITS-1:0] shift_q;
    logic [BW-1:0]            bit_cnt;
    logic [TW-1:0]            tcnt;

`ifdef PS2_RX_PARITY_CHECK_EN
    logic par_bit;
    logic perr_q;
    logic parity_bad;

    assign parity_bad   = ~^{shift_q, par_bit};
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

    // Frame FSM with mid-frame timeout; a falling edge always beats the timeout.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            shift_q          <= '0;
            bit_cnt          <= '0;
            tcnt             <= '0;
            received_data    <= '0;
            received_data_en <= 1'b0;
            frame_error      <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
            par_bit          <= 1'b0;
            perr_q           <= 1'b0;
`endif
        end else begin
            received_data_en <= 1'b0;
            frame_error      <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
            perr_q           <= 1'b0;
`endif
            if (take) begin
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (!sdat) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_q <= {sdat, shift_q[PS2_DATA_BITS-1:1]};
                        if (bit_cnt == BW'(PS2_DATA_BITS - 1)) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
                        par_bit <= sdat;
`endif
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!sdat) begin
                            frame_error <= 1'b1;
                        end
`ifdef PS2_RX_PARITY_CHECK_EN
                        else if (parity_bad) begin
                            perr_q <= 1'b1;
                        end
`endif
                        else begin
                            received_data    <= shift_q;
                            received_data_en <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state       <= IDLE;
                shift_q     <= '0;
                bit_cnt     <= '0;
                tcnt        <= '0;
                frame_error <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: directed frames push expected events,
// a negedge monitor pops and compares each output pulse.
module tb_ps2_rx_frame;

    localparam int unsigned FL   = 8;
    localparam int unsigned TO   = 5000;
    localparam int unsigned HALF = 40;

    logic       clock   = 1'b0;
    logic       resetn  = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       parity_error;
    logic       frame_error;

    ps2_rx_frame #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .ps2_clk          (ps2_clk),
        .ps2_dat          (ps2_dat),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .parity_error     (parity_error),
        .frame_error      (frame_error)
    );

    always #10 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef enum int {EV_DATA = 0, EV_PERR = 1, EV_FERR = 2} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [7:0]  data;
        int unsigned lo;
        int unsigned hi;
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned last_fall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [7:0] d,
                             input int unsigned lo, input int unsigned hi);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.lo   = lo;
        e.hi   = hi;
        exp_q.push_back(e);
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clock) begin
        ev_t      e;
        ev_kind_t k;
        if (resetn && (received_data_en || parity_error || frame_error)) begin
            k = received_data_en ? EV_DATA : (parity_error ? EV_PERR : EV_FERR);
            check("one_output_high",
                  32'(received_data_en) + 32'(parity_error) + 32'(frame_error), 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got kind %0d data %0h at cycle %0d expected none",
                         k, received_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", 32'(k), 32'(e.kind));
                if (e.kind == EV_DATA) check("event_data", 32'(received_data), 32'(e.data));
                if (e.hi != 0) begin
                    n_checks++;
                    if (cyc >= e.lo && cyc <= e.hi) n_pass++;
                    else $display("FAIL event_cycle: got cycle %0d expected %0d..%0d", cyc, e.lo, e.hi);
                end
            end
        end
    end

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clk_pulse(input logic b);
        ps2_dat = b;
        wait_cyc(HALF);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        clk_pulse(1'b0);
        for (int i = 0; i < 8; i++) clk_pulse(d[i]);
        clk_pulse(par);
        clk_pulse(stop);
        ps2_dat = 1'b1;
    endtask

    task automatic drain(input string name, input int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        wait_cyc(20);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        // reset state
        wait_cyc(5);
        check("reset_data", 32'(received_data), 32'h00);
        check("reset_en", 32'(received_data_en), 32'd0);
        check("reset_perr", 32'(parity_error), 32'd0);
        check("reset_ferr", 32'(frame_error), 32'd0);
        resetn = 1'b1;
        wait_cyc(20);

        // single valid byte
        expect_ev(EV_DATA, 8'h1D, 0, 0);
        send_frame(8'h1D, 1'b1, 1'b1);
        drain("valid_drain", 500);
        check("valid_hold", 32'(received_data), 32'h1D);

        // back-to-back frames
        expect_ev(EV_DATA, 8'hF0, 0, 0);
        expect_ev(EV_DATA, 8'h29, 0, 0);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h29, 1'b0, 1'b1);
        drain("b2b_drain", 500);
        wait_cyc(100);
        check("b2b_hold", 32'(received_data), 32'h29);

        // bad parity on E0
`ifdef PS2_RX_PARITY_CHECK_EN
        expect_ev(EV_PERR, 8'h00, 0, 0);
        send_frame(8'hE0, 1'b1, 1'b1);
        drain("parity_drain", 500);
        check("parity_hold", 32'(received_data), 32'h29);
`else
        expect_ev(EV_DATA, 8'hE0, 0, 0);
        send_frame(8'hE0, 1'b1, 1'b1);
        drain("parity_drain", 500);
        check("parity_hold", 32'(received_data), 32'hE0);
`endif

        // start bit 1 while idle
        expect_ev(EV_FERR, 8'h00, 0, 0);
        clk_pulse(1'b1);
        drain("start_drain", 500);

        // stop bit 0 on 1C
        expect_ev(EV_FERR, 8'h00, 0, 0);
        send_frame(8'h1C, 1'b0, 1'b0);
        drain("stop_drain", 500);
`ifdef PS2_RX_PARITY_CHECK_EN
        check("stop_hold", 32'(received_data), 32'h29);
`else
        check("stop_hold", 32'(received_data), 32'hE0);
`endif

        // timeout after 4 data bits, then a good frame
        clk_pulse(1'b0);
        clk_pulse(1'b1);
        clk_pulse(1'b0);
        clk_pulse(1'b1);
        clk_pulse(1'b1);
        ps2_dat = 1'b1;
        expect_ev(EV_FERR, 8'h00, last_fall + TO + 5, last_fall + TO + 17);
        drain("timeout_drain", TO + 500);
        expect_ev(EV_DATA, 8'h75, 0, 0);
        send_frame(8'h75, 1'b0, 1'b1);
        drain("after_timeout_drain", 500);

        // short clock glitch while data is low must not start a frame
        ps2_dat = 1'b0;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(50);
        ps2_dat = 1'b1;
        wait_cyc(20);
        expect_ev(EV_DATA, 8'h1D, 0, 0);
        send_frame(8'h1D, 1'b1, 1'b1);
        drain("glitch_drain", 500);

        // reset mid-frame
        clk_pulse(1'b0);
        clk_pulse(1'b1);
        clk_pulse(1'b0);
        ps2_dat = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(20);
        resetn = 1'b0;
        #1;
        check("midreset_data", 32'(received_data), 32'h00);
        check("midreset_en", 32'(received_data_en), 32'd0);
        check("midreset_perr", 32'(parity_error), 32'd0);
        check("midreset_ferr", 32'(frame_error), 32'd0);
        wait_cyc(5);
        ps2_clk = 1'b1;
        wait_cyc(5);
        resetn = 1'b1;
        wait_cyc(20);
        expect_ev(EV_DATA, 8'h5A, 0, 0);
        send_frame(8'h5A, 1'b1, 1'b1);
        drain("after_reset_drain", 500);
        check("after_reset_hold", 32'(received_data), 32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        n_checks++;
        $display("FAIL watchdog: got no completion expected finish before 5ms");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
